rf_dbg_master: RTL and testbench

//   Initiator-side driver for the register-file port (read-address / write-enable / write-data).

---
 rtl/rf_dbg_master_if.sv | 30 +++
 rtl/rf_dbg_master.sv | 179 +++++++++++++++++
 tb/tb_rf_dbg_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dbg_master_if.sv
// Debug command / response channel between a host and rf_dbg_master.
//   cmd_*  : host -> master command (valid/ready), op, register address, write data
//   rsp_*  : master -> host response beats (valid/ready), address, data, last flag
// Modports: master = host side, slave = rf_dbg_master side.
interface rf_dbg_master_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
    );
endinterface

// File: rtl/rf_dbg_master.sv
// Initiator-side driver for a register file: turns debug commands
// (READ / WRITE / DUMP / CLEAR) into register-file accesses.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     command channel in, response beats out
//   busy            high whenever not idle
//   rf_reg_s1       rf read address (rf read data returns combinationally)
//   rf_rd           rf write address
//   rf_write_e      rf write enable (rf commits on the edge it is high)
//   rf_write_d      rf write data
//   rf_reg_d1       rf read data for rf_reg_s1
module rf_dbg_master #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    rf_dbg_master_if.slave    bus,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_reg_s1,
    output logic [ADDR_W-1:0] rf_rd,
    output logic              rf_write_e,
    output logic [DATA_W-1:0] rf_write_d,
    input  logic [DATA_W-1:0] rf_reg_d1
);
    localparam int unsigned LAST_IDX = NUM_REGS - 1;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR, RD, RSP, CLR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              dump_q, dump_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic [ADDR_W-1:0] rf_reg_s1_q, rf_reg_s1_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic              rf_write_e_q, rf_write_e_d;
    logic [DATA_W-1:0] rf_write_d_q, rf_write_d_d;
    logic              accept;

    // Register exists in the file (address space may be larger than NUM_REGS).
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign busy          = (state_q != IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign rf_reg_s1     = rf_reg_s1_q;
    assign rf_rd         = rf_rd_q;
    assign rf_write_e    = rf_write_e_q;
    assign rf_write_d    = rf_write_d_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dump_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            rf_reg_s1_q  <= '0;
            rf_rd_q      <= '0;
            rf_write_e_q <= 1'b0;
            rf_write_d_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dump_q       <= dump_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
            rf_reg_s1_q  <= rf_reg_s1_d;
            rf_rd_q      <= rf_rd_d;
            rf_write_e_q <= rf_write_e_d;
            rf_write_d_q <= rf_write_d_d;
        end
    end

    // Next-state and next-output logic; write enable is a one-cycle pulse by default.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dump_d       = dump_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_last_d   = rsp_last_q;
        rf_reg_s1_d  = rf_reg_s1_q;
        rf_rd_d      = rf_rd_q;
        rf_write_e_d = 1'b0;
        rf_write_d_d = rf_write_d_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (bus.cmd_op)
                        OP_READ: begin
                            rf_reg_s1_d = bus.cmd_addr;
                            dump_d      = 1'b0;
                            state_d     = RD;
                        end
                        OP_WRITE: begin
                            // x0 is hard-wired zero; out-of-range addresses are dropped.
                            rf_rd_d      = bus.cmd_addr;
                            rf_write_d_d = bus.cmd_data;
                            rf_write_e_d = (bus.cmd_addr != '0) && in_range(bus.cmd_addr);
                            state_d      = WR;
                        end
                        OP_DUMP: begin
                            cnt_d       = '0;
                            rf_reg_s1_d = '0;
                            dump_d      = 1'b1;
                            state_d     = RD;
                        end
                        OP_CLEAR: begin
                            // Start at x1: x0 is never written.
                            cnt_d        = ADDR_W'(1);
                            rf_rd_d      = ADDR_W'(1);
                            rf_write_d_d = '0;
                            rf_write_e_d = 1'b1;
                            state_d      = CLR;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                // rf read data is valid this cycle for the address driven last edge.
                rsp_data_d  = in_range(rf_reg_s1_q) ? rf_reg_d1 : '0;
                rsp_addr_d  = rf_reg_s1_q;
                rsp_last_d  = !dump_q || (cnt_q == ADDR_W'(LAST_IDX));
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d       = cnt_q + ADDR_W'(1);
                        rf_reg_s1_d = cnt_q + ADDR_W'(1);
                        state_d     = RD;
                    end
                end
            end
            CLR: begin
                if (cnt_q == ADDR_W'(LAST_IDX)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d        = cnt_q + ADDR_W'(1);
                    rf_rd_d      = cnt_q + ADDR_W'(1);
                    rf_write_e_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rf_dbg_master.sv
// Self-checking bench for rf_dbg_master: a register file model sits on the rf port,
// and an independent array of expected register contents is updated per command.
module tb_rf_dbg_master;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM    = 32;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic              clk;
    logic              rst;
    logic              busy;
    logic [ADDR_W-1:0] rf_reg_s1;
    logic [ADDR_W-1:0] rf_rd;
    logic              rf_write_e;
    logic [DATA_W-1:0] rf_write_d;
    logic [DATA_W-1:0] rf_reg_d1;
    logic              rf_init;

    logic [DATA_W-1:0] rf_mem [NUM];
    logic [DATA_W-1:0] exp_regs [NUM];

    int checks = 0;
    int errors = 0;

    rf_dbg_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_dbg_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .rf_reg_s1  (rf_reg_s1),
        .rf_rd      (rf_rd),
        .rf_write_e (rf_write_e),
        .rf_write_d (rf_write_d),
        .rf_reg_d1  (rf_reg_d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file attached to the DUT: combinational read, write on the edge.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < NUM; i++) rf_mem[i] <= '0;
        end else if (rf_write_e) begin
            rf_mem[rf_rd] <= rf_write_d;
        end
    end
    assign rf_reg_d1 = rf_mem[rf_reg_s1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after it is idle again.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic exp_we;
        exp_we = (a != 0) && (int'(a) < NUM);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_addr = a; bus.cmd_data = d;
        chk("wr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_we", 64'(rf_write_e), 64'(exp_we));
        if (exp_we) begin
            chk("wr_addr", 64'(rf_rd), 64'(a));
            chk("wr_data", 64'(rf_write_d), 64'(d));
        end
        @(negedge clk);
        chk("wr_we_pulse", 64'(rf_write_e), 64'd0);
        chk("wr_idle", 64'(busy), 64'd0);
        chk("wr_no_rsp", 64'(bus.rsp_valid), 64'd0);
        if (exp_we) exp_regs[a] = d;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int stall, input bit hold_valid);
        logic [DATA_W-1:0] ev;
        ev = (int'(a) < NUM) ? exp_regs[a] : '0;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = a;
        bus.cmd_data = DATA_W'($urandom); bus.rsp_ready = 1'b0;
        chk("rd_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        if (!hold_valid) bus.cmd_valid = 1'b0;
        chk("rd_early_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rd_raddr", 64'(rf_reg_s1), 64'(a));
        chk("rd_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("rd_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rd_data", 64'(bus.rsp_data), 64'(ev));
        chk("rd_addr", 64'(bus.rsp_addr), 64'(a));
        chk("rd_last", 64'(bus.rsp_last), 64'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rd_stall_valid", 64'(bus.rsp_valid), 64'd1);
            chk("rd_stall_data", 64'(bus.rsp_data), 64'(ev));
            chk("rd_stall_no_accept", 64'(bus.cmd_ready), 64'd0);
            chk("rd_stall_we", 64'(rf_write_e), 64'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rd_done_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rd_done_ready", 64'(bus.cmd_ready), 64'd1);
    endtask

    // mode 0: rsp_ready toggles, 1: random, 2: always ready
    task automatic do_dump(input int mode);
        int idx, cyc;
        bit held, tog, r;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] s_data;
        logic s_last;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_DUMP; bus.cmd_addr = ADDR_W'($urandom);
        bus.rsp_ready = 1'b0;
        chk("dump_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        idx = 0; cyc = 0; held = 1'b0; tog = 1'b1;
        s_addr = '0; s_data = '0; s_last = 1'b0;
        while (idx < NUM && cyc < 2000) begin
            if (bus.rsp_valid) begin
                if (held) begin
                    chk("dump_stall_addr", 64'(bus.rsp_addr), 64'(s_addr));
                    chk("dump_stall_data", 64'(bus.rsp_data), 64'(s_data));
                    chk("dump_stall_last", 64'(bus.rsp_last), 64'(s_last));
                end
                case (mode)
                    0: begin r = tog; tog = !tog; end
                    1: r = bit'($urandom_range(0, 1));
                    default: r = 1'b1;
                endcase
                bus.rsp_ready = r;
                if (r) begin
                    chk("dump_addr", 64'(bus.rsp_addr), 64'(idx));
                    chk("dump_data", 64'(bus.rsp_data), 64'(exp_regs[idx]));
                    chk("dump_last", 64'(bus.rsp_last), 64'(idx == NUM - 1));
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    s_addr = bus.rsp_addr; s_data = bus.rsp_data; s_last = bus.rsp_last;
                end
            end else begin
                bus.rsp_ready = 1'b0;
            end
            if (rf_write_e) chk("dump_we", 64'(rf_write_e), 64'd0);
            @(negedge clk);
            cyc++;
        end
        bus.rsp_ready = 1'b0;
        if (cyc >= 2000) chk("dump_timeout", 64'(idx), 64'(NUM));
        chk("dump_done_busy", 64'(busy), 64'd0);
        chk("dump_done_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic do_clear();
        int k;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_CLEAR; bus.cmd_addr = ADDR_W'($urandom);
        chk("clr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            chk("clr_we", 64'(rf_write_e), 64'd1);
            chk("clr_rd", 64'(rf_rd), 64'(k + 1));
            chk("clr_wd", 64'(rf_write_d), 64'd0);
            k++;
            @(negedge clk);
        end
        chk("clr_len", 64'(k), 64'(NUM - 1));
        chk("clr_we_off", 64'(rf_write_e), 64'd0);
        for (int i = 1; i < NUM; i++) exp_regs[i] = '0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; rf_init = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_READ; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM; i++) exp_regs[i] = '0;
        repeat (3) @(negedge clk);
        rf_init = 1'b0;

        // Reset state
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_last", 64'(bus.rsp_last), 64'd0);
        chk("rst_rsp_addr", 64'(bus.rsp_addr), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_we", 64'(rf_write_e), 64'd0);
        chk("rst_s1", 64'(rf_reg_s1), 64'd0);
        chk("rst_rd", 64'(rf_rd), 64'd0);
        chk("rst_wd", 64'(rf_write_d), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);

        // Write then read-after-write
        do_write(5'd4, 32'd42);
        do_read(5'd4, 0, 1'b0);

        // x0 is never written
        do_write(5'd0, 32'd99);
        do_read(5'd0, 0, 1'b0);

        // Dump with toggling rsp_ready
        do_write(5'd2, 32'd99);
        do_dump(0);

        // Clear followed by an all-zero dump
        do_write(5'd31, 32'hDEAD_BEEF);
        do_clear();
        do_dump(2);

        // Reset in the middle of a dump at beat 10
        do_write(5'd4, 32'd42);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_DUMP;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cyc = 0;
        while (!(bus.rsp_valid && bus.rsp_addr == 5'd10) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_reach_beat10", 64'(bus.rsp_addr), 64'd10);
        rst = 1'b1; bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rstmid_we", 64'(rf_write_e), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_cmd_ready_in_rst", 64'(bus.cmd_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rstmid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        do_read(5'd4, 0, 1'b0);

        // cmd_valid held through a stalled READ: no second accept
        do_write(5'd7, 32'h1234_5678);
        do_read(5'd7, 5, 1'b1);
        chk("hold_no_reaccept", 64'(busy), 64'd0);

        // Randomized command sequence against the expected register array
        for (int n = 0; n < 40; n++) begin
            int op;
            logic [ADDR_W-1:0] a;
            op = int'($urandom_range(0, 9));
            a  = ADDR_W'($urandom);
            if (op < 4)       do_write(a, DATA_W'($urandom));
            else if (op < 8)  do_read(a, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            else if (op == 8) do_dump(1);
            else              do_clear();
        end
        do_dump(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
